// File: rtl/nr_w1_strb_memory_pkg.sv
// Shared defaults, types and address helpers for the N-read / 1-write strobed memory.
package nr_w1_strb_memory_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 32;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int MEM_BYTES_DEFAULT  = 4096;

  typedef logic [DATA_WIDTH_DEFAULT/8-1:0] strb_t;

  // Word index of a byte address; addresses are zero-extended to 64 bits by the caller
  function automatic logic [63:0] word_idx(input logic [63:0] addr, input int unsigned lane_bits);
    return addr >> lane_bits;
  endfunction

  // Full-width range check: no wrap-around, so huge addresses are simply out of range
  function automatic logic in_range(input logic [63:0] addr, input int unsigned lane_bits,
                                    input logic [63:0] bytes);
    logic [63:0] words;
    words = bytes >> lane_bits;
    return word_idx(addr, lane_bits) < words;
  endfunction

endpackage

// File: rtl/nr_w1_strb_memory_pipe_delay.sv
// Reset-to-zero shift register carrying one read beat {valid, err, data} per stage.
module nr_w1_strb_memory_pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift beats forward each cycle; reset drops everything in flight
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/nr_w1_strb_memory.sv
// N-read / 1-write word memory with byte strobes, pipelined reads, range checking
// and a selectable read-during-write policy.
//
// Handshake: there is no ready. Every cycle with r_en_i[p]=1 is an accepted request,
// answered by exactly one r_valid_o[p] pulse RD_LATENCY cycles later, in order.
// r_err_o[p] is only meaningful while r_valid_o[p]=1. r_data_o[p] holds between valids.
module nr_w1_strb_memory
  import nr_w1_strb_memory_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int MEM_BYTES   = MEM_BYTES_DEFAULT,
  parameter int NUM_RD      = 2,
  parameter int RD_LATENCY  = 1,
  parameter int WRITE_FIRST = 1
) (
  input  logic                                clk_i,
  input  logic                                arst_i,
  input  logic                                we_i,
  input  logic [ADDR_WIDTH-1:0]               w_addr_i,
  input  logic [DATA_WIDTH-1:0]               w_data_i,
  input  logic [DATA_WIDTH/8-1:0]             w_strb_i,
  output logic                                w_err_o,
  input  logic [NUM_RD-1:0]                   r_en_i,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   r_addr_i,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   r_data_o,
  output logic [NUM_RD-1:0]                   r_valid_o,
  output logic [NUM_RD-1:0]                   r_err_o
);

  localparam int          BPW       = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(BPW);
  localparam int          WORDS     = MEM_BYTES / BPW;
  localparam int          IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int          PW        = DATA_WIDTH + 2;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  logic [63:0]      w_widx;
  logic             w_inr;
  logic             wr_en;
  logic [IDX_W-1:0] w_idx;
  logic             w_err_q;
  logic             unused_w_hi;

  assign w_widx      = word_idx(64'(w_addr_i), LANE_BITS);
  assign w_inr       = in_range(64'(w_addr_i), LANE_BITS, 64'(MEM_BYTES));
  assign w_idx       = w_widx[IDX_W-1:0];
  // Writes presented during reset are ignored, as are out-of-range writes
  assign wr_en       = we_i & ~arst_i & w_inr;
  assign unused_w_hi = ^w_widx[63:IDX_W];

  // Array write: only strobed lanes of an in-range word change; contents survive reset
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < BPW; b++) begin
        if (w_strb_i[b]) mem_q[w_idx][b*8 +: 8] <= w_data_i[b*8 +: 8];
      end
    end
  end

  // Range error for any write request, including strobe-less ones
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) w_err_q <= 1'b0;
    else        w_err_q <= we_i & ~w_inr;
  end

  assign w_err_o = w_err_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [63:0]           widx;
    logic                  inr;
    logic                  hit;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [PW-1:0]         beat_d;
    logic [PW-1:0]         beat_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  unused_hi;

    assign widx      = word_idx(64'(r_addr_i[p]), LANE_BITS);
    assign inr       = in_range(64'(r_addr_i[p]), LANE_BITS, 64'(MEM_BYTES));
    assign old_word  = mem_q[widx[IDX_W-1:0]];
    assign hit       = (WRITE_FIRST != 0) && wr_en && (widx == w_widx);
    assign unused_hi = ^widx[63:IDX_W];

    // Write-first bypass: strobed lanes of a same-word write replace the stored bytes
    always_comb begin
      rd_word = old_word;
      if (hit) begin
        for (int b = 0; b < BPW; b++) begin
          if (w_strb_i[b]) rd_word[b*8 +: 8] = w_data_i[b*8 +: 8];
        end
      end
    end

    // Data is captured at request time so later writes cannot disturb it
    assign beat_d = {r_en_i[p], r_en_i[p] & ~inr, inr ? rd_word : {DATA_WIDTH{1'b0}}};

    nr_w1_strb_memory_pipe_delay #(
      .WIDTH (PW),
      .DEPTH (RD_LATENCY)
    ) u_pipe (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .d_i    (beat_d),
      .q_o    (beat_q)
    );

    // Remember the last delivered word so r_data_o holds between valids
    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i)              hold_q <= '0;
      else if (beat_q[PW-1])   hold_q <= beat_q[DATA_WIDTH-1:0];
    end

    assign r_valid_o[p] = beat_q[PW-1];
    assign r_err_o[p]   = beat_q[PW-2];
    assign r_data_o[p]  = beat_q[PW-1] ? beat_q[DATA_WIDTH-1:0] : hold_q;
  end

`ifndef SYNTHESIS
  // Backdoor peek for benches; out-of-range addresses read as zero
  function automatic logic [DATA_WIDTH-1:0] read(input logic [ADDR_WIDTH-1:0] addr);
    logic [63:0] idx;
    idx = word_idx(64'(addr), LANE_BITS);
    if (!in_range(64'(addr), LANE_BITS, 64'(MEM_BYTES))) return '0;
    return mem_q[idx[IDX_W-1:0]];
  endfunction
`endif

endmodule

// File: tb/tb_nr_w1_strb_memory.sv
// Bench for nr_w1_strb_memory: three configurations driven in lock-step against a
// byte-array reference model with per-port expected-response queues.
module tb_nr_w1_strb_memory;

  localparam int MEM_BYTES = 4096;
  localparam int ND        = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic arst;

  // ---------------- DUT signals ----------------
  logic        we     [ND];
  logic [31:0] w_addr [ND];
  logic [31:0] w_data [ND];
  logic [3:0]  w_strb [ND];
  logic        w_err  [ND];
  logic [3:0]  r_en   [ND];
  logic [31:0] r_addr [ND][4];

  logic [1:0][31:0] r_data_a;  logic [1:0] r_valid_a, r_err_a;
  logic [3:0][31:0] r_data_b;  logic [3:0] r_valid_b, r_err_b;
  logic [1:0][31:0] r_data_c;  logic [1:0] r_valid_c, r_err_c;

  // A: 2 ports, latency 1, write-first
  nr_w1_strb_memory #(.MEM_BYTES(MEM_BYTES), .NUM_RD(2), .RD_LATENCY(1), .WRITE_FIRST(1)) dut_a (
    .clk_i(clk), .arst_i(arst), .we_i(we[0]), .w_addr_i(w_addr[0]), .w_data_i(w_data[0]),
    .w_strb_i(w_strb[0]), .w_err_o(w_err[0]), .r_en_i(r_en[0][1:0]),
    .r_addr_i({r_addr[0][1], r_addr[0][0]}),
    .r_data_o(r_data_a), .r_valid_o(r_valid_a), .r_err_o(r_err_a));

  // B: 4 ports, latency 3, read-first
  nr_w1_strb_memory #(.MEM_BYTES(MEM_BYTES), .NUM_RD(4), .RD_LATENCY(3), .WRITE_FIRST(0)) dut_b (
    .clk_i(clk), .arst_i(arst), .we_i(we[1]), .w_addr_i(w_addr[1]), .w_data_i(w_data[1]),
    .w_strb_i(w_strb[1]), .w_err_o(w_err[1]), .r_en_i(r_en[1]),
    .r_addr_i({r_addr[1][3], r_addr[1][2], r_addr[1][1], r_addr[1][0]}),
    .r_data_o(r_data_b), .r_valid_o(r_valid_b), .r_err_o(r_err_b));

  // C: 2 ports, latency 2, write-first
  nr_w1_strb_memory #(.MEM_BYTES(MEM_BYTES), .NUM_RD(2), .RD_LATENCY(2), .WRITE_FIRST(1)) dut_c (
    .clk_i(clk), .arst_i(arst), .we_i(we[2]), .w_addr_i(w_addr[2]), .w_data_i(w_data[2]),
    .w_strb_i(w_strb[2]), .w_err_o(w_err[2]), .r_en_i(r_en[2][1:0]),
    .r_addr_i({r_addr[2][1], r_addr[2][0]}),
    .r_data_o(r_data_c), .r_valid_o(r_valid_c), .r_err_o(r_err_c));

  function automatic int nr(input int d);
    return (d == 1) ? 4 : 2;
  endfunction
  function automatic int lat(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
  endfunction
  function automatic bit wf(input int d);
    return (d != 1);
  endfunction

  function automatic logic o_valid(input int d, input int p);
    case (d)
      0:       return r_valid_a[p[0]];
      1:       return r_valid_b[p[1:0]];
      default: return r_valid_c[p[0]];
    endcase
  endfunction
  function automatic logic o_err(input int d, input int p);
    case (d)
      0:       return r_err_a[p[0]];
      1:       return r_err_b[p[1:0]];
      default: return r_err_c[p[0]];
    endcase
  endfunction
  function automatic logic [31:0] o_data(input int d, input int p);
    case (d)
      0:       return r_data_a[p[0]];
      1:       return r_data_b[p[1:0]];
      default: return r_data_c[p[0]];
    endcase
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  mem_m  [ND][MEM_BYTES];
  logic [31:0] hold_m [ND][4];
  logic        werr_m [ND];
  logic [64:0] exp_q  [ND*4][$];   // {due cycle, err, data}
  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int d, input int p,
                       input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d port%0d observed=%0h expected=%0h", tag, d, p, obs, exp);
    end
  endtask

  // Apply one clock edge to the model, advance the DUTs, then compare every output
  task automatic step();
    logic [31:0] widx, word;
    logic        w_in, err;
    logic [64:0] e;
    int          qi;
    for (int d = 0; d < ND; d++) begin
      if (arst) begin
        for (int p = 0; p < 4; p++) begin
          exp_q[d*4+p].delete();
          hold_m[d][p] = 32'h0;
        end
        werr_m[d] = 1'b0;
      end else begin
        w_in = (w_addr[d] >> 2) < 32'(MEM_BYTES/4);
        for (int p = 0; p < nr(d); p++) begin
          if (r_en[d][p]) begin
            widx = r_addr[d][p] >> 2;
            word = 32'h0;
            err  = (widx >= 32'(MEM_BYTES/4));
            if (!err) begin
              for (int b = 0; b < 4; b++) begin
                word[8*b +: 8] = mem_m[d][int'(widx)*4 + b];
                if (wf(d) && we[d] && w_in && ((w_addr[d] >> 2) == widx) && w_strb[d][b])
                  word[8*b +: 8] = w_data[d][8*b +: 8];
              end
            end
            exp_q[d*4+p].push_back({32'(cyc + lat(d)), err, word});
          end
        end
        if (we[d] && w_in) begin
          for (int b = 0; b < 4; b++)
            if (w_strb[d][b]) mem_m[d][int'(w_addr[d] >> 2)*4 + b] = w_data[d][8*b +: 8];
        end
        werr_m[d] = we[d] && !w_in;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int d = 0; d < ND; d++) begin
      check("w_err", d, 0, 64'(w_err[d]), 64'(werr_m[d]));
      for (int p = 0; p < nr(d); p++) begin
        qi = d*4 + p;
        e  = (exp_q[qi].size() > 0) ? exp_q[qi][0] : 65'h0;
        if (exp_q[qi].size() > 0 && int'(e[64:33]) == cyc) begin
          void'(exp_q[qi].pop_front());
          hold_m[d][p] = e[31:0];
          check("r_valid", d, p, 64'(o_valid(d, p)), 64'(1'b1));
          check("r_err",   d, p, 64'(o_err(d, p)),   64'(e[32]));
          check("r_data",  d, p, 64'(o_data(d, p)),  64'(e[31:0]));
        end else begin
          check("r_valid_idle", d, p, 64'(o_valid(d, p)), 64'(1'b0));
          check("r_data_hold",  d, p, 64'(o_data(d, p)),  64'(hold_m[d][p]));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    for (int d = 0; d < ND; d++) begin
      we[d]     = 1'b0;
      w_strb[d] = 4'h0;
      r_en[d]   = 4'h0;
    end
  endtask

  task automatic wr_all(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int d = 0; d < ND; d++) begin
      we[d] = 1'b1; w_addr[d] = addr; w_data[d] = data; w_strb[d] = strb;
    end
  endtask

  task automatic rd_all(input int p, input logic [31:0] addr);
    for (int d = 0; d < ND; d++) begin
      if (p < nr(d)) begin
        r_en[d][p]   = 1'b1;
        r_addr[d][p] = addr;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 19);
    if (k == 0) return 32'(MEM_BYTES) + 32'($urandom_range(0, 255));
    if (k == 1) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    if (k == 2) return 32'(MEM_BYTES - 4) + 32'($urandom_range(0, 3));
    return 32'($urandom_range(0, 127));
  endfunction

  task automatic rand_step();
    for (int d = 0; d < ND; d++) begin
      we[d]     = 1'($urandom_range(0, 1));
      w_addr[d] = rand_addr();
      w_data[d] = $urandom;
      w_strb[d] = 4'($urandom_range(0, 15));
      r_en[d]   = 4'($urandom_range(0, 15));
      for (int p = 0; p < 4; p++) r_addr[d][p] = rand_addr();
    end
    step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    arst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      w_addr[d] = 32'h0; w_data[d] = 32'h0;
      for (int p = 0; p < 4; p++) begin r_addr[d][p] = 32'h0; hold_m[d][p] = 32'h0; end
      werr_m[d] = 1'b0;
    end
    idle();
    // Requests during reset are ignored
    wr_all(32'h0, 32'h1234_5678, 4'hF);
    rd_all(0, 32'h0);
    repeat (3) step();
    idle();
    arst = 1'b0;

    // Fill the working region and the last word
    for (int w = 0; w < 32; w++) begin
      idle(); wr_all(32'(w*4), $urandom, 4'hF); step();
    end
    idle(); wr_all(32'(MEM_BYTES - 4), 32'h5A5A_A5A5, 4'hF); step();

    // Full write then a read through an unaligned address
    idle(); wr_all(32'h10, 32'hDEAD_BEEF, 4'hF); step();
    idle(); rd_all(0, 32'h12); step();
    check("basic_valid", 0, 0, 64'(r_valid_a[0]), 64'(1'b1));
    check("basic_data",  0, 0, 64'(r_data_a[0]),  64'h0000_0000_DEAD_BEEF);
    check("basic_err",   0, 0, 64'(r_err_a[0]),   64'(1'b0));

    // Partial strobe merge
    idle(); wr_all(32'h20, 32'h1122_3344, 4'hF); step();
    idle(); wr_all(32'h20, 32'hAABB_CCDD, 4'h5); step();
    idle(); rd_all(0, 32'h20); step();
    check("strb_merge", 0, 0, 64'(r_data_a[0]), 64'h0000_0000_11BB_33DD);

    // Same-cycle read and write of one word
    idle(); wr_all(32'h30, 32'h0, 4'hF); step();
    idle(); wr_all(32'h30, 32'hCAFE_F00D, 4'hF); rd_all(0, 32'h30); step();
    check("rdw_write_first_lat1", 0, 0, 64'(r_data_a[0]), 64'h0000_0000_CAFE_F00D);
    idle(); step();
    check("rdw_write_first_lat2", 2, 0, 64'(r_data_c[0]), 64'h0000_0000_CAFE_F00D);
    idle(); step();
    check("rdw_read_first_valid", 1, 0, 64'(r_valid_b[0]), 64'(1'b1));
    check("rdw_read_first_data",  1, 0, 64'(r_data_b[0]),  64'h0);

    // Back-to-back reads on every port
    for (int c = 0; c < 4; c++) begin
      idle();
      for (int p = 0; p < 4; p++) rd_all(p, 32'($urandom_range(0, 127)));
      step();
    end
    idle(); repeat (4) step();

    // First out-of-range word and a no-wrap address
    idle(); wr_all(32'(MEM_BYTES), 32'h0BAD_0BAD, 4'hF); rd_all(1, 32'(MEM_BYTES)); step();
    check("oor_r_err",  0, 1, 64'(r_err_a[1]),  64'(1'b1));
    check("oor_r_data", 0, 1, 64'(r_data_a[1]), 64'h0);
    check("oor_w_err",  0, 0, 64'(w_err[0]),    64'(1'b1));
    idle(); rd_all(0, 32'(MEM_BYTES - 4)); rd_all(1, 32'hFFFF_FFFC); step();
    check("last_word_kept", 0, 0, 64'(r_data_a[0]), 64'h0000_0000_5A5A_A5A5);
    idle(); repeat (3) step();

    // Strobe-less writes still report range
    idle(); wr_all(32'h40, $urandom, 4'h0); step();
    idle(); wr_all(32'(MEM_BYTES + 8), $urandom, 4'h0); step();
    check("strb0_oor_w_err", 1, 0, 64'(w_err[1]), 64'(1'b1));
    idle(); rd_all(0, 32'h40); repeat (4) step();

    // Randomised traffic
    repeat (600) rand_step();
    idle(); repeat (4) step();

    // Reset with reads in flight
    idle(); rd_all(0, 32'h10); rd_all(1, 32'h14); step();
    idle(); rd_all(0, 32'h18); rd_all(1, 32'h1C); step();
    idle();
    arst = 1'b1;
    step();
    check("rst_inflight_valid", 2, 0, 64'(r_valid_c[0]), 64'(1'b0));
    check("rst_inflight_data",  2, 0, 64'(r_data_c[0]),  64'h0);
    step();
    arst = 1'b0;
    repeat (4) step();
    for (int w = 0; w < 8; w++) begin
      idle(); rd_all(0, 32'(w*4)); rd_all(1, 32'(MEM_BYTES - 4)); step();
    end
    idle(); repeat (4) step();

    for (int i = 0; i < ND*4; i++) check("queue_drained", i/4, i%4, 64'(exp_q[i].size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
